uart_cmd_parser: RTL and testbench

- Command-frame engine that sits directly downstream of the UART block. It consumes received bytes from the UART RX FIFO (pop interface) and produces response bytes into the UART TX FIFO (push interface).
- It decodes a fixed 5-byte register-access frame and drives a simple 8-bit register bus.
- It replies ACK/NAK, plus read data for reads.
- It provides host-PC control of on-board registers over the serial link.

---
 rtl/uart_cmd_parser_pkg.sv | 14 +
 rtl/uart_gap_timer.sv | 21 ++
 rtl/uart_cmd_parser.sv | 120 ++++++++++++
 tb/tb_uart_cmd_parser.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// uart_cmd_pkg: frame constants and FSM state encoding shared by the command parser.
package uart_cmd_pkg;
    localparam logic [7:0] SOF    = 8'hA5;
    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    // receive states are consecutive so the FSM can step through them by increment
    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK,
        S_EXEC, S_RDWAIT, S_ACK, S_RDATA, S_NAK
    } state_t;
endpackage

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: inter-byte gap counter; expire fires when the gap reaches TIMEOUT-1 with no byte.
module uart_gap_timer #(
    parameter int TIMEOUT = 1000000,
    parameter int TO_BIT  = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    logic [TO_BIT-1:0] cnt_q, cnt_d;

    assign cnt_d    = (clr_i || !en_i) ? '0 : cnt_q + 1'b1;
    // an arriving byte beats an expiry in the same cycle
    assign expire_o = en_i && !clr_i && cnt_q == TO_BIT'(TIMEOUT - 1);

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes 5-byte register-access frames from the UART RX FIFO,
// drives an 8-bit register bus and answers ACK/NAK (plus read data) into the TX FIFO.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT = 1000000,
    parameter int TO_BIT  = 20
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_empty_i,
    input  logic [7:0] rx_data_i,
    output logic       rd_uart_o,
    input  logic       tx_full_i,
    output logic       wr_uart_o,
    output logic [7:0] tx_data_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    output logic       reg_re_o,
    input  logic [7:0] reg_rdata_i,
    output logic       frame_err_o,
    output logic       busy_o
);
    state_t     state_q, state_d;
    logic [7:0] cmd_q, cmd_d, addr_q, addr_d, data_q, data_d, chk_q, chk_d, rbuf_q, rbuf_d;
    logic       good_q, good_d;
    logic       rcv, accept, expire;

    assign rcv         = state_q inside {S_CMD, S_ADDR, S_DATA, S_CHK};
    assign accept      = (rcv || state_q == S_IDLE) && !rx_empty_i;
    assign rd_uart_o   = accept;
    assign busy_o      = state_q != S_IDLE;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = data_q;

    assign cmd_d  = (accept && state_q == S_CMD)  ? rx_data_i : cmd_q;
    assign addr_d = (accept && state_q == S_ADDR) ? rx_data_i : addr_q;
    assign data_d = (accept && state_q == S_DATA) ? rx_data_i : data_q;
    assign good_d = (accept && state_q == S_CHK)
                  ? (rx_data_i == chk_q) && (cmd_q == CMD_WR || cmd_q == CMD_RD) : good_q;
    assign rbuf_d = (state_q == S_RDWAIT) ? reg_rdata_i : rbuf_q;

    uart_gap_timer #(.TIMEOUT(TIMEOUT), .TO_BIT(TO_BIT)) u_gap (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (accept),
        .en_i     (rcv),
        .expire_o (expire)
    );

    always_comb begin
        state_d     = state_q;
        chk_d       = chk_q;
        wr_uart_o   = 1'b0;
        tx_data_o   = 8'h00;
        reg_we_o    = 1'b0;
        reg_re_o    = 1'b0;
        frame_err_o = 1'b0;
        case (state_q)
            S_IDLE: if (accept && rx_data_i == SOF) begin
                state_d = S_CMD;
                chk_d   = 8'h00;
            end
            S_CMD, S_ADDR, S_DATA, S_CHK: if (accept) begin
                state_d = state_t'(state_q + 4'd1);
                chk_d   = chk_q ^ rx_data_i;
            end else if (expire) begin
                state_d     = S_IDLE;
                frame_err_o = 1'b1;
            end
            S_EXEC: if (!good_q) begin
                frame_err_o = 1'b1;
                state_d     = S_NAK;
            end else if (cmd_q == CMD_WR) begin
                reg_we_o = 1'b1;
                state_d  = S_ACK;
            end else begin
                reg_re_o = 1'b1;
                state_d  = S_RDWAIT;
            end
            S_RDWAIT: state_d = S_ACK;
            S_ACK: begin
                tx_data_o = ACK;
                wr_uart_o = !tx_full_i;
                if (!tx_full_i) state_d = (cmd_q == CMD_RD) ? S_RDATA : S_IDLE;
            end
            S_RDATA: begin
                tx_data_o = rbuf_q;
                wr_uart_o = !tx_full_i;
                if (!tx_full_i) state_d = S_IDLE;
            end
            S_NAK: begin
                tx_data_o = NAK;
                wr_uart_o = !tx_full_i;
                if (!tx_full_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            chk_q   <= '0;
            rbuf_q  <= '0;
            good_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            chk_q   <= chk_d;
            rbuf_q  <= rbuf_d;
            good_q  <= good_d;
        end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed frames into a modelled RX FIFO; a monitor checks TX bytes
// and register writes against queues filled when each frame is issued.
module tb_uart_cmd_parser;
    localparam int TO = 100;

    logic       clk_i = 1'b0, rst_ni = 1'b0, rx_empty_i = 1'b1, tx_full_i = 1'b0;
    logic [7:0] rx_data_i = 8'h00, reg_rdata_i = 8'h00;
    logic       rd_uart_o, wr_uart_o, reg_we_o, reg_re_o, frame_err_o, busy_o;
    logic [7:0] tx_data_o, reg_addr_o, reg_wdata_o;

    logic [7:0]  rxq[$], txq[$];
    logic [15:0] wrq[$];
    int checks = 0, fails = 0, errs = 0, res = 0, wrs = 0, pops = 0;
    logic pop_pend = 1'b0, re_pend = 1'b0;
    logic [7:0] rd_val = 8'h9E, exp_raddr = 8'h00;

    uart_cmd_parser #(.TIMEOUT(TO), .TO_BIT(20)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .rx_empty_i(rx_empty_i), .rx_data_i(rx_data_i),
        .rd_uart_o(rd_uart_o), .tx_full_i(tx_full_i), .wr_uart_o(wr_uart_o), .tx_data_o(tx_data_o),
        .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_we_o(reg_we_o), .reg_re_o(reg_re_o),
        .reg_rdata_i(reg_rdata_i), .frame_err_o(frame_err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk_i);
            #3;
        end
    endtask

    task automatic push5(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d, logic [7:0] e);
        rxq.push_back(a); rxq.push_back(b); rxq.push_back(c); rxq.push_back(d); rxq.push_back(e);
    endtask

    task automatic drain(string name);
        int k;
        for (k = 0; k < 300; k++) begin
            if (txq.size() == 0 && wrq.size() == 0 && rxq.size() == 0 && !busy_o) break;
            tick(1);
        end
        chk({name, "_pending"}, txq.size() + wrq.size(), 0);
        chk({name, "_busy"}, busy_o, 0);
    endtask

    // RX FIFO and register-read model; inputs change only on the falling edge
    initial forever begin
        @(negedge clk_i);
        if (pop_pend && rxq.size() > 0) void'(rxq.pop_front());
        rx_empty_i  = rxq.size() == 0;
        rx_data_i   = rx_empty_i ? 8'h00 : rxq[0];
        reg_rdata_i = re_pend ? rd_val : 8'h00;
        #1;
        pop_pend = rd_uart_o && rst_ni;
        re_pend  = reg_re_o && rst_ni;
    end

    always @(negedge clk_i) begin
        #2;
        if (rst_ni) begin
            if (rd_uart_o) begin
                pops++;
                chk("rd_on_empty", rx_empty_i, 0);
            end
            if (wr_uart_o) begin
                wrs++;
                chk("wr_while_full", tx_full_i, 0);
                if (txq.size() == 0) chk("tx_unexpected", tx_data_o, 32'h1FF);
                else chk("tx_byte", tx_data_o, txq.pop_front());
            end
            if (reg_we_o) begin
                if (wrq.size() == 0) chk("we_unexpected", {reg_addr_o, reg_wdata_o}, 32'h1FFFF);
                else chk("reg_write", {reg_addr_o, reg_wdata_o}, wrq.pop_front());
            end
            if (reg_re_o) begin
                res++;
                chk("re_addr", reg_addr_o, exp_raddr);
            end
            if (frame_err_o) errs++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e, r, w, p;
        tick(3);
        chk("rst_rd_uart", rd_uart_o, 0);
        chk("rst_wr_uart", wr_uart_o, 0);
        chk("rst_tx_data", tx_data_o, 0);
        chk("rst_reg_we", reg_we_o, 0);
        chk("rst_reg_re", reg_re_o, 0);
        chk("rst_reg_addr", reg_addr_o, 0);
        chk("rst_reg_wdata", reg_wdata_o, 0);
        chk("rst_frame_err", frame_err_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_ni = 1'b1;
        tick(2);

        e = errs; r = res;
        wrq.push_back({8'h10, 8'h3C}); txq.push_back(8'h06);
        push5(8'hA5, 8'h57, 8'h10, 8'h3C, 8'h7B);
        drain("write");
        chk("write_err", errs - e, 0);
        chk("write_re", res - r, 0);

        e = errs; r = res; exp_raddr = 8'h22;
        txq.push_back(8'h06); txq.push_back(8'h9E);
        push5(8'hA5, 8'h52, 8'h22, 8'h00, 8'h70);
        drain("read");
        chk("read_re", res - r, 1);
        chk("read_err", errs - e, 0);
        chk("hold_addr", reg_addr_o, 8'h22);

        e = errs;
        txq.push_back(8'h15);
        push5(8'hA5, 8'h57, 8'h10, 8'h3C, 8'h00);
        drain("badchk");
        chk("badchk_err", errs - e, 1);

        e = errs; r = res;
        txq.push_back(8'h15);
        push5(8'hA5, 8'h41, 8'h10, 8'h3C, 8'h6D);
        drain("badcmd");
        chk("badcmd_err", errs - e, 1);
        chk("badcmd_re", res - r, 0);

        e = errs;
        rxq.push_back(8'h00); rxq.push_back(8'hFF);
        wrq.push_back({8'h01, 8'h02}); txq.push_back(8'h06);
        push5(8'hA5, 8'h57, 8'h01, 8'h02, 8'h54);
        drain("junk");
        chk("junk_err", errs - e, 0);

        e = errs; w = wrs;
        rxq.push_back(8'hA5); rxq.push_back(8'h57);
        tick(TO + 20);
        chk("timeout_err", errs - e, 1);
        chk("timeout_busy", busy_o, 0);
        chk("timeout_tx", wrs - w, 0);
        wrq.push_back({8'h20, 8'h55}); txq.push_back(8'h06);
        push5(8'hA5, 8'h57, 8'h20, 8'h55, 8'h22);
        drain("after_timeout");

        // byte presented exactly on the last permitted gap cycle is accepted
        e = errs;
        rxq.push_back(8'hA5);
        for (int k = 0; k < 50 && !busy_o; k++) tick(1);
        tick(TO - 1);
        wrq.push_back({8'h10, 8'h3C}); txq.push_back(8'h06);
        rxq.push_back(8'h57); rxq.push_back(8'h10); rxq.push_back(8'h3C); rxq.push_back(8'h7B);
        drain("gap_edge_ok");
        chk("gap_edge_ok_err", errs - e, 0);

        // one cycle later the timeout wins and the rest of the frame is discarded
        e = errs; w = wrs;
        rxq.push_back(8'hA5);
        for (int k = 0; k < 50 && !busy_o; k++) tick(1);
        tick(TO);
        rxq.push_back(8'h57); rxq.push_back(8'h10); rxq.push_back(8'h3C); rxq.push_back(8'h7B);
        drain("gap_edge_to");
        chk("gap_edge_to_err", errs - e, 1);
        chk("gap_edge_to_tx", wrs - w, 0);

        tx_full_i = 1'b1;
        w = wrs; exp_raddr = 8'h22;
        wrq.push_back({8'h10, 8'h3C});
        push5(8'hA5, 8'h57, 8'h10, 8'h3C, 8'h7B);
        push5(8'hA5, 8'h52, 8'h22, 8'h00, 8'h70);
        tick(10);
        p = pops;
        tick(40);
        chk("full_no_pop", pops - p, 0);
        chk("full_rx_held", rxq.size(), 5);
        chk("full_no_wr", wrs - w, 0);
        txq.push_back(8'h06); txq.push_back(8'h06); txq.push_back(8'h9E);
        tx_full_i = 1'b0;
        @(negedge clk_i);
        #3;
        chk("full_release_wr", wrs - w, 1);
        drain("full");

        w = wrs;
        tx_full_i = 1'b1;
        wrq.push_back({8'h33, 8'h44});
        push5(8'hA5, 8'h57, 8'h33, 8'h44, 8'h20);
        tick(15);
        rst_ni = 1'b0;
        tick(2);
        tx_full_i = 1'b0;
        chk("midrst_busy", busy_o, 0);
        rst_ni = 1'b1;
        tick(20);
        chk("midrst_no_wr", wrs - w, 0);
        chk("midrst_write_done", wrq.size(), 0);
        chk("midrst_idle", busy_o, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
